// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT_BITS result bits per clock through one
// shared slice, carry held in a flip-flop between digits.
module serial_addsub #(
  parameter int WIDTH      = 8,
  parameter int DIGIT_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int STEPS = WIDTH / DIGIT_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  c_q, c_d, msba_q, msba_d, msbb_q, msbb_d;
  logic                  carry_q, carry_d, ovf_q, ovf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIGIT_BITS:0]   digit_sum;
  logic [WIDTH-1:0]      res_shift, opb_in;
  logic                  accept, last;

  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt_q == CW'(STEPS - 1));
  assign opb_in = sub ? ~b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Low digit of each operand plus carry; new digit enters the result MSB end.
  assign digit_sum = {1'b0, opa_q[DIGIT_BITS-1:0]} + {1'b0, opb_q[DIGIT_BITS-1:0]}
                   + {{DIGIT_BITS{1'b0}}, c_q};
  assign res_shift = (res_q >> DIGIT_BITS)
                   | (WIDTH'(digit_sum[DIGIT_BITS-1:0]) << (WIDTH - DIGIT_BITS));

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    c_d     = c_q;
    msba_d  = msba_q;
    msbb_d  = msbb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      opa_d  = a;
      opb_d  = opb_in;
      c_d    = sub ? 1'b1 : cin;
      msba_d = a[WIDTH-1];
      msbb_d = opb_in[WIDTH-1];
      cnt_d  = '0;
      res_d  = '0;
    end else if (state_q == RUN) begin
      opa_d = opa_q >> DIGIT_BITS;
      opb_d = opb_q >> DIGIT_BITS;
      c_d   = digit_sum[DIGIT_BITS];
      res_d = res_shift;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        sum_d   = res_shift;
        carry_d = digit_sum[DIGIT_BITS];
        ovf_d   = (msba_q == msbb_q) && (res_shift[WIDTH-1] != msba_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      msba_q  <= 1'b0;
      msbb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      c_q     <= c_d;
      msba_q  <= msba_d;
      msbb_q  <= msbb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
endmodule
